// File: rtl/endpoint_select.sv
// Debounces city hits from the mouse detector and captures a begin/end city pair,
// then hands the pair to the path engine over a req/ack handshake.
module endpoint_select #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] pos_x_in,
   input  logic [9:0] pos_y_in,
   input  logic       clear,
   input  logic       search_ack,
   output logic [9:0] begin_x,
   output logic [9:0] begin_y,
   output logic [9:0] end_x,
   output logic [9:0] end_y,
   output logic       begin_valid,
   output logic       end_valid,
   output logic       search_req,
   output logic       done
);

   localparam logic [7:0] Target = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {StIdle, StWaitEnd, StReq, StDone} state_e;

   state_e      state_q;
   logic [19:0] sample;
   logic [19:0] prev_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        arm_q;
   logic        hold_q;
   logic        hit;
   logic        new_hit;
   logic        confirm;
   logic        accept;

   assign sample  = {pos_x_in, pos_y_in};
   assign hit     = |sample;
   assign new_hit = hit && (sample != prev_q);

   // hold_q keeps a press that spans reset/clear from counting until it is released
   always_comb begin
      cnt_d = 8'd0;
      if (hit && !hold_q) begin
         if (new_hit)                cnt_d = 8'd1;
         else if (cnt_q != 8'hff)    cnt_d = cnt_q + 8'd1;
         else                        cnt_d = cnt_q;
      end
   end

   // Fires once per press, or again after a mid-press coordinate change restarts the count
   assign confirm = hit && !hold_q && (cnt_d == Target) && (new_hit || (cnt_q != Target));
   assign accept  = confirm && arm_q;

   always_ff @(posedge Clk) begin
      if (!Reset || clear) begin
         state_q     <= StIdle;
         prev_q      <= 20'd0;
         cnt_q       <= 8'd0;
         arm_q       <= 1'b1;
         hold_q      <= 1'b1;
         begin_x     <= 10'd0;
         begin_y     <= 10'd0;
         end_x       <= 10'd0;
         end_y       <= 10'd0;
         begin_valid <= 1'b0;
         end_valid   <= 1'b0;
         search_req  <= 1'b0;
         done        <= 1'b0;
      end else begin
         prev_q <= sample;
         cnt_q  <= cnt_d;
         if (confirm)   arm_q <= 1'b0;
         else if (!hit) arm_q <= 1'b1;
         if (!hit) hold_q <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  begin_x     <= pos_x_in;
                  begin_y     <= pos_y_in;
                  begin_valid <= 1'b1;
                  state_q     <= StWaitEnd;
               end
            end
            StWaitEnd: begin
               if (accept && (sample != {begin_x, begin_y})) begin
                  end_x     <= pos_x_in;
                  end_y     <= pos_y_in;
                  end_valid <= 1'b1;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               // ack only counts once the request is visible to the engine
               if (!search_req) begin
                  search_req <= 1'b1;
               end else if (search_ack) begin
                  search_req <= 1'b0;
                  done       <= 1'b1;
                  state_q    <= StDone;
               end
            end
            StDone: begin
               state_q <= StDone;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_endpoint_select.sv
// Scoreboard bench for endpoint_select: expected output snapshots are queued per edge
// while stimulus is driven and compared by a monitor just after that edge.
module tb_endpoint_select;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [9:0] pos_x_in;
   logic [9:0] pos_y_in;
   logic       clear;
   logic       search_ack;
   logic [9:0] begin_x, begin_y, end_x, end_y;
   logic       begin_valid, end_valid, search_req, done;

   endpoint_select #(.STABLE_CYCLES(4)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .pos_x_in    (pos_x_in),
      .pos_y_in    (pos_y_in),
      .clear       (clear),
      .search_ack  (search_ack),
      .begin_x     (begin_x),
      .begin_y     (begin_y),
      .end_x       (end_x),
      .end_y       (end_y),
      .begin_valid (begin_valid),
      .end_valid   (end_valid),
      .search_req  (search_req),
      .done        (done)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          e;
      string       tag;
      logic [43:0] val;
   } exp_t;

   exp_t sb[$];
   int   edges  = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [43:0] mk(input logic [9:0] bx, input logic [9:0] by,
                                      input logic [9:0] ex, input logic [9:0] ey,
                                      input logic bv, input logic ev,
                                      input logic rq, input logic dn);
      return {bx, by, ex, ey, bv, ev, rq, dn};
   endfunction

   function automatic logic [43:0] snap();
      return {begin_x, begin_y, end_x, end_y, begin_valid, end_valid, search_req, done};
   endfunction

   // Sorted insert so expectations may be queued in any order
   task automatic push(input int e, input string tag, input logic [43:0] v);
      exp_t it;
      int   idx;
      it.e   = e;
      it.tag = tag;
      it.val = v;
      idx    = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].e > e) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, it);
   endtask

   // Inputs change at the negedge and are sampled by the following posedge
   task automatic apply(input logic [9:0] x, input logic [9:0] y, input int n);
      for (int i = 0; i < n; i++) begin
         pos_x_in = x;
         pos_y_in = y;
         @(negedge Clk);
      end
   endtask

   always @(posedge Clk) begin
      exp_t it;
      edges = edges + 1;
      #1;
      while (sb.size() > 0 && sb[0].e <= edges) begin
         it = sb.pop_front();
         if (it.e < edges) check({it.tag, "_edge"}, 64'(edges), 64'(it.e));
         else              check(it.tag, {20'd0, snap()}, {20'd0, it.val});
      end
   end

   localparam logic [9:0] AX = 10'd465, AY = 10'd186;
   localparam logic [9:0] BX = 10'd530, BY = 10'd301;
   localparam logic [9:0] CX = 10'd426, CY = 10'd407;
   localparam logic [9:0] DX = 10'd478, DY = 10'd199;

   int k;

   initial begin
      logic [43:0] z;
      z          = mk(10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      Reset      = 1'b0;
      clear      = 1'b0;
      search_ack = 1'b0;
      pos_x_in   = 10'd0;
      pos_y_in   = 10'd0;
      repeat (2) @(negedge Clk);
      push(edges + 1, "reset", z);
      apply(10'd0, 10'd0, 1);
      Reset = 1'b1;
      apply(10'd0, 10'd0, 2);

      // Three-cycle press is too short
      k = edges + 1;
      push(k + 2, "short_press", z);
      apply(AX, AY, 3);
      push(edges + 1, "short_rel", z);
      apply(10'd0, 10'd0, 2);

      // Begin capture after the fourth edge, end after release and second city
      k = edges + 1;
      push(k + 2, "pre_cap", z);
      push(k + 3, "begin_cap", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(AX, AY, 6);
      apply(10'd0, 10'd0, 1);
      k = edges + 1;
      push(k + 2, "pre_end", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      push(k + 3, "end_cap", mk(AX, AY, BX, BY, 1'b1, 1'b1, 1'b0, 1'b0));
      push(k + 4, "req_rise", mk(AX, AY, BX, BY, 1'b1, 1'b1, 1'b1, 1'b0));
      push(k + 5, "req_hold", mk(AX, AY, BX, BY, 1'b1, 1'b1, 1'b1, 1'b0));
      push(k + 6, "done_rise", mk(AX, AY, BX, BY, 1'b1, 1'b1, 1'b0, 1'b1));
      apply(BX, BY, 4);
      apply(10'd0, 10'd0, 2);
      search_ack = 1'b1;
      apply(10'd0, 10'd0, 1);
      search_ack = 1'b0;
      apply(10'd0, 10'd0, 1);
      k = edges + 1;
      push(k + 4, "done_held", mk(AX, AY, BX, BY, 1'b1, 1'b1, 1'b0, 1'b1));
      apply(CX, CY, 5);

      clear = 1'b1;
      push(edges + 1, "clear", z);
      apply(10'd0, 10'd0, 1);
      clear = 1'b0;
      apply(10'd0, 10'd0, 1);

      // One long press fills only begin
      k = edges + 1;
      push(k + 3, "long_begin", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      push(k + 19, "long_no_end", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(AX, AY, 20);
      apply(10'd0, 10'd0, 1);

      // Re-clicking the begin city is discarded
      k = edges + 1;
      push(k + 3, "same_discard", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(AX, AY, 4);
      apply(10'd0, 10'd0, 1);
      k = edges + 1;
      push(k + 3, "end_c", mk(AX, AY, CX, CY, 1'b1, 1'b1, 1'b0, 1'b0));
      push(k + 4, "req_c", mk(AX, AY, CX, CY, 1'b1, 1'b1, 1'b1, 1'b0));
      apply(CX, CY, 4);
      apply(10'd0, 10'd0, 1);

      // clear beats a simultaneous ack
      clear      = 1'b1;
      search_ack = 1'b1;
      push(edges + 1, "clr_ack", z);
      apply(10'd0, 10'd0, 1);
      clear = 1'b0;
      push(edges + 1, "clr_after", z);
      apply(10'd0, 10'd0, 1);
      search_ack = 1'b0;

      // Alternating cities never settle; a glitch to 0 restarts the count
      k = edges + 1;
      push(k + 7, "alternate", z);
      for (int i = 0; i < 2; i++) begin
         apply(AX, AY, 2);
         apply(DX, DY, 2);
      end
      k = edges + 1;
      push(k + 5, "glitch_pre", z);
      push(k + 6, "glitch_cap", mk(AX, AY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(AX, AY, 2);
      apply(10'd0, 10'd0, 1);
      apply(AX, AY, 4);
      apply(10'd0, 10'd0, 1);

      // Reset mid-press: held click is ignored until released and pressed again
      apply(CX, CY, 2);
      Reset = 1'b0;
      push(edges + 1, "rst_mid", z);
      apply(CX, CY, 1);
      Reset = 1'b1;
      k = edges + 1;
      push(k + 5, "rst_held", z);
      apply(CX, CY, 6);
      apply(10'd0, 10'd0, 1);
      k = edges + 1;
      push(k + 2, "repress_pre", z);
      push(k + 3, "repress", mk(CX, CY, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(CX, CY, 4);
      apply(10'd0, 10'd0, 3);

      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/endpoint_select.md
# endpoint_select

Registers the start and destination cities for the route search. It sits directly downstream of the mouse city-detector, which outputs a city's snapped pixel coordinate while the left button is held over that city, and 0/0 otherwise. This block debounces those hits and captures the first confirmed click as the begin city and the next distinct click as the end city. It then hands the pair to the shortest-path engine over a req/ack handshake and holds it for the path renderer until cleared.

## Interface
- STABLE_CYCLES, 4: consecutive identical non-zero samples required to confirm a click (legal range 1..255).
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- pos_x_in  in  10  city X from the detector; 0 means no hit.
- pos_y_in  in  10  city Y from the detector; 0 means no hit.
- clear  in  1  synchronous restart, active-high (right button). Priority below Reset, above everything else.
- search_ack  in  1  path engine accepted the request.
- begin_x, begin_y  out  10 each  captured start city.
- end_x, end_y  out  10 each  captured destination city.
- begin_valid  out  1  begin coordinates are valid.
- end_valid  out  1  end coordinates are valid.
- search_req  out  1  request to the path engine.
- done  out  1  the engine has accepted the current pair.

## Operation
- A hit is any cycle where {pos_x_in, pos_y_in} is not 0/0.
- Stability counter (8 bits) and previous-sample register:
  - Counter loads 1 on a hit that differs from the previous sample.
  - Counter increments, saturating, on a hit equal to the previous sample.
  - Counter loads 0 on no hit.
- A click is confirmed on the edge where the counter reaches STABLE_CYCLES. This happens at most once per press.
- Arm flag:
  - Cleared on each confirmation.
  - Set after one sampled no-hit cycle.
  - A confirmation is ignored while the flag is clear. This stops one long press from filling both begin and end.
- States:
  - IDLE → on confirmation: capture begin_x/y, set begin_valid → WAIT_END.
  - WAIT_END → on confirmation with coordinates ≠ begin: capture end_x/y, set end_valid → REQ. A confirmation equal to begin is discarded and the state stays WAIT_END.
  - REQ: search_req=1 → on search_ack → DONE.
  - DONE: done=1, search_req=0, all coordinates held. Further clicks are ignored.
- clear or Reset in any state:
  - Go to IDLE.
  - All coordinate outputs = 0; begin_valid, end_valid, search_req, done = 0.
  - Counter = 0, previous sample = 0, arm = 1.
  - A click held across clear must be released before it can count.
- Simultaneous events:
  - clear with search_ack: clear wins, no DONE.
  - search_ack outside REQ: ignored.

## Timing
- Reset value of every output is 0.
- Confirmation latency:
  - Non-zero input first sampled at edge k.
  - With STABLE_CYCLES=N, the captured coordinates and valid flag are visible after edge k+N−1.
  - N=1 means capture on the first sampled hit.
- search_req rises in the cycle after end_valid rises and holds steady until search_ack is sampled high.
  - It falls, and done rises, after that same edge.
  - Zero-wait ack (ack already high when req rises) is legal and gives a one-cycle req.
- A mid-press change of coordinates restarts the count at 1. The count never wraps, because it saturates at 255.
- clear takes effect at the next edge; outputs are 0 the following cycle.

## Test plan
- Reset, N=4: hold 465/186 for 4 cycles → begin=465/186, begin_valid after the 4th edge. Hold 3 cycles only → no capture.
- Click 465/186 for 6 cycles, release 1 cycle, click 530/301 for 4 cycles → end=530/301, search_req next cycle. Ack 3 cycles later → req falls, done=1, values held.
- Hold 465/186 for 20 cycles without release → only begin captured; end_valid stays 0.
- After begin=465/186: release, then click 465/186 again for 4 cycles → discarded, stay WAIT_END. Then 426/407 → end captured.
- Input alternating 465/186 and 478/199 every 2 cycles → no capture. Glitch to 0 on cycle 3 of 4 → counter restarts.
- Assert clear in REQ while ack is high → all outputs 0, no done. Assert Reset mid-press → outputs 0, and the held click is not captured until released and pressed again.
